// File: rtl/unified_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : unified_mem_ctrl
// Purpose  : Single-bank on-chip memory shared by an instruction fetch port
//            and a data read/write port. It has round-robin or fixed-priority
//            arbitration, programmable wait states and byte-masked writes.
//            Each access ends with a one-cycle ready pulse on its own port.
// Ports    : clk, rst              - clock, synchronous active-high reset
//            instr_read/addr       - fetch request (held until instr_ready)
//            instr_out/ready       - registered fetch word, completion pulse
//            data_read/write/addr  - data request; write = per-byte strobes
//            data_in               - write data
//            data_out/ready        - registered read word (pre-write value)
//            busy                  - high whenever the FSM is not idle
// Revision : 1.0 - initial release
// ============================================================================
module unified_mem_ctrl #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int DEPTH_LOG2 = 14,
  parameter int WAIT       = 1,
  parameter int ARB_MODE   = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  instr_read,
  input  logic [ADDR_W-1:0]     instr_addr,
  output logic [DATA_W-1:0]     instr_out,
  output logic                  instr_ready,
  input  logic                  data_read,
  input  logic [DATA_W/8-1:0]   data_write,
  input  logic [ADDR_W-1:0]     data_addr,
  input  logic [DATA_W-1:0]     data_in,
  output logic [DATA_W-1:0]     data_out,
  output logic                  data_ready,
  output logic                  busy
);

  localparam int STRB_W = DATA_W / 8;
  localparam int OFF_W  = (STRB_W > 1) ? $clog2(STRB_W) : 0;
  localparam int DEPTH  = 2 ** DEPTH_LOG2;

  // Port identifiers used for the grant latch and last_grant.
  localparam logic GRANT_INSTR = 1'b0;
  localparam logic GRANT_DATA  = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  logic [DATA_W-1:0] mem [DEPTH];

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  port_q, port_d;
  logic [DEPTH_LOG2-1:0] idx_q, idx_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [STRB_W-1:0]     strb_q, strb_d;
  logic                  last_grant_q, last_grant_d;
  logic [DATA_W-1:0]     instr_out_q, instr_out_d;
  logic [DATA_W-1:0]     data_out_q, data_out_d;
  logic                  instr_ready_q, instr_ready_d;
  logic                  data_ready_q, data_ready_d;

  logic                  instr_req;
  logic                  data_req;
  logic                  grant_data;
  logic                  access;
  logic [DEPTH_LOG2-1:0] acc_idx;
  logic [DATA_W-1:0]     acc_wdata;
  logic [STRB_W-1:0]     acc_strb;
  logic                  acc_port;
  logic [DATA_W-1:0]     rd_word;
  logic                  unused_addr_bits;

  // Offset and upper address bits are intentionally ignored (aliasing).
  assign unused_addr_bits = ^{instr_addr, data_addr};

  assign instr_req = instr_read;
  assign data_req  = data_read | (|data_write);

  // Data wins a tie when fixed priority is selected or when instruction
  // had the previous grant; a lone requester is always granted.
  assign grant_data = data_req &&
                      (!instr_req || (ARB_MODE == 1) || (last_grant_q == GRANT_INSTR));

  // Read sees the array before this edge's write (read-before-write).
  assign rd_word = mem[acc_idx];

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    port_d        = port_q;
    idx_d         = idx_q;
    wdata_d       = wdata_q;
    strb_d        = strb_q;
    last_grant_d  = last_grant_q;
    instr_out_d   = instr_out_q;
    data_out_d    = data_out_q;
    instr_ready_d = 1'b0;
    data_ready_d  = 1'b0;
    access        = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (instr_req || data_req) begin
          port_d       = grant_data;
          idx_d        = grant_data ? data_addr[OFF_W +: DEPTH_LOG2]
                                    : instr_addr[OFF_W +: DEPTH_LOG2];
          wdata_d      = data_in;
          // The instruction port never writes.
          strb_d       = grant_data ? data_write : '0;
          last_grant_d = grant_data;
          cnt_d        = 4'(WAIT);
          if (WAIT == 0) begin
            state_d = S_DONE;
            access  = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = S_DONE;
          access  = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // With zero wait states the access happens on the grant edge itself,
    // so the freshly latched values are used instead of the stored ones.
    acc_idx   = idx_d;
    acc_wdata = wdata_d;
    acc_strb  = strb_d;
    acc_port  = port_d;

    if (access) begin
      if (acc_port == GRANT_DATA) begin
        data_out_d   = rd_word;
        data_ready_d = 1'b1;
      end else begin
        instr_out_d   = rd_word;
        instr_ready_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= 4'd0;
      port_q        <= GRANT_INSTR;
      idx_q         <= '0;
      wdata_q       <= '0;
      strb_q        <= '0;
      last_grant_q  <= GRANT_DATA;
      instr_out_q   <= '0;
      data_out_q    <= '0;
      instr_ready_q <= 1'b0;
      data_ready_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      port_q        <= port_d;
      idx_q         <= idx_d;
      wdata_q       <= wdata_d;
      strb_q        <= strb_d;
      last_grant_q  <= last_grant_d;
      instr_out_q   <= instr_out_d;
      data_out_q    <= data_out_d;
      instr_ready_q <= instr_ready_d;
      data_ready_q  <= data_ready_d;
    end
  end

  // Array is never cleared; reset only blocks an access that has not yet
  // reached its access edge.
  always_ff @(posedge clk) begin
    if (!rst && access) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (acc_strb[b]) begin
          mem[acc_idx][b*8 +: 8] <= acc_wdata[b*8 +: 8];
        end
      end
    end
  end

  assign instr_out   = instr_out_q;
  assign instr_ready = instr_ready_q;
  assign data_out    = data_out_q;
  assign data_ready  = data_ready_q;
  assign busy        = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_unified_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_unified_mem_ctrl
// Purpose  : Scoreboard bench for unified_mem_ctrl. Four instances cover
//            WAIT=1 round-robin, ARB_MODE=1, WAIT=3 with mid-access reset,
//            and DEPTH_LOG2=4 aliasing. Stimulus pushes expected responses
//            (word and ready cycle) and per-port monitors pop and compare.
// Revision : 1.0 - initial release
// ============================================================================
module tb_unified_mem_ctrl;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [3:0]  rst_v;
  logic [3:0]  i_rd;
  logic [3:0]  d_rd;
  logic [3:0]  i_rdy;
  logic [3:0]  d_rdy;
  logic [3:0]  bsy;
  logic [31:0] i_addr [4];
  logic [31:0] d_addr [4];
  logic [31:0] d_din  [4];
  logic [31:0] i_out  [4];
  logic [31:0] d_out  [4];
  logic [3:0]  d_wr   [4];

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    bit          chk;
    logic [31:0] d;
    int          cyc;
  } exp_t;

  // Queue index = 2*instance + port (port 0 = instr, 1 = data).
  exp_t sbq [8][$];

  function automatic int wt(input int k);
    return (k == 2) ? 3 : 1;
  endfunction

  unified_mem_ctrl #(.WAIT(1), .ARB_MODE(0), .DEPTH_LOG2(14)) u0 (
    .clk(clk), .rst(rst_v[0]),
    .instr_read(i_rd[0]), .instr_addr(i_addr[0]), .instr_out(i_out[0]), .instr_ready(i_rdy[0]),
    .data_read(d_rd[0]), .data_write(d_wr[0]), .data_addr(d_addr[0]), .data_in(d_din[0]),
    .data_out(d_out[0]), .data_ready(d_rdy[0]), .busy(bsy[0]));

  unified_mem_ctrl #(.WAIT(1), .ARB_MODE(1), .DEPTH_LOG2(14)) u1 (
    .clk(clk), .rst(rst_v[1]),
    .instr_read(i_rd[1]), .instr_addr(i_addr[1]), .instr_out(i_out[1]), .instr_ready(i_rdy[1]),
    .data_read(d_rd[1]), .data_write(d_wr[1]), .data_addr(d_addr[1]), .data_in(d_din[1]),
    .data_out(d_out[1]), .data_ready(d_rdy[1]), .busy(bsy[1]));

  unified_mem_ctrl #(.WAIT(3), .ARB_MODE(0), .DEPTH_LOG2(14)) u2 (
    .clk(clk), .rst(rst_v[2]),
    .instr_read(i_rd[2]), .instr_addr(i_addr[2]), .instr_out(i_out[2]), .instr_ready(i_rdy[2]),
    .data_read(d_rd[2]), .data_write(d_wr[2]), .data_addr(d_addr[2]), .data_in(d_din[2]),
    .data_out(d_out[2]), .data_ready(d_rdy[2]), .busy(bsy[2]));

  unified_mem_ctrl #(.WAIT(1), .ARB_MODE(0), .DEPTH_LOG2(4)) u3 (
    .clk(clk), .rst(rst_v[3]),
    .instr_read(i_rd[3]), .instr_addr(i_addr[3]), .instr_out(i_out[3]), .instr_ready(i_rdy[3]),
    .data_read(d_rd[3]), .data_write(d_wr[3]), .data_addr(d_addr[3]), .data_in(d_din[3]),
    .data_out(d_out[3]), .data_ready(d_rdy[3]), .busy(bsy[3]));

  // Monitors: one per (instance, port), sampling on the falling edge.
  for (genvar g = 0; g < 8; g++) begin : g_mon
    localparam int K = g / 2;
    localparam int P = g % 2;
    always @(negedge clk) begin
      logic        rdy;
      logic [31:0] val;
      exp_t        e;
      rdy = (P == 1) ? d_rdy[K] : i_rdy[K];
      val = (P == 1) ? d_out[K] : i_out[K];
      if (rdy) begin
        n_cmp++;
        if (sbq[g].size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_ready inst%0d port%0d: ready seen in cycle %0d, required none",
                   K, P, cyc);
        end else begin
          e = sbq[g].pop_front();
          if (cyc != e.cyc) begin
            n_bad++;
            $display("FAIL ready_cycle inst%0d port%0d: got cycle %0d, required %0d",
                     K, P, cyc, e.cyc);
          end
          if (e.chk) begin
            n_cmp++;
            if (val !== e.d) begin
              n_bad++;
              $display("FAIL read_word inst%0d port%0d: got %08h, required %08h",
                       K, P, val, e.d);
            end
          end
        end
      end
    end
  end

  function automatic exp_t mk(input bit chk, input logic [31:0] d, input int c);
    exp_t e;
    e.chk = chk;
    e.d   = d;
    e.cyc = c;
    return e;
  endfunction

  // Issue one data-port access, hold it until ready, then release it.
  task automatic data_op(input int k, input logic [3:0] wr, input logic rd,
                         input logic [31:0] addr, input logic [31:0] din,
                         input bit chk, input logic [31:0] exp_d);
    bit seen;
    @(posedge clk); #1;
    d_rd[k]   = rd;
    d_wr[k]   = wr;
    d_addr[k] = addr;
    d_din[k]  = din;
    sbq[2*k+1].push_back(mk(chk, exp_d, cyc + 1 + wt(k)));
    seen = 1'b0;
    for (int n = 0; n < 40 && !seen; n++) begin
      @(negedge clk);
      if (d_rdy[k]) seen = 1'b1;
    end
    if (!seen) begin
      n_cmp++;
      n_bad++;
      $display("FAIL data_timeout inst%0d: got no data_ready, required one within 40 cycles", k);
    end
    @(posedge clk); #1;
    d_rd[k] = 1'b0;
    d_wr[k] = 4'h0;
  endtask

  initial begin
    int c;
    rst_v = 4'hF;
    i_rd  = 4'h0;
    d_rd  = 4'h0;
    for (int k = 0; k < 4; k++) begin
      i_addr[k] = '0;
      d_addr[k] = '0;
      d_din[k]  = '0;
      d_wr[k]   = 4'h0;
    end
    repeat (2) @(posedge clk);
    #1 rst_v = 4'h0;
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      n_cmp++;
      if ({i_out[k], d_out[k], i_rdy[k], d_rdy[k], bsy[k]} !== '0) begin
        n_bad++;
        $display("FAIL reset_state inst%0d: got out %08h/%08h rdy %b%b busy %b, required all zero",
                 k, i_out[k], d_out[k], i_rdy[k], d_rdy[k], bsy[k]);
      end
    end

    // Full write, read back, masked write, read+write, read back.
    data_op(0, 4'hF,    1'b0, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0);
    data_op(0, 4'h0,    1'b1, 32'h10, 32'h0,        1'b1, 32'hDEADBEEF);
    data_op(0, 4'b0010, 1'b0, 32'h10, 32'h0000AA00, 1'b1, 32'hDEADBEEF);
    data_op(0, 4'h0,    1'b1, 32'h10, 32'h0,        1'b1, 32'hDEADAAEF);
    data_op(0, 4'hF,    1'b1, 32'h10, 32'h11111111, 1'b1, 32'hDEADAAEF);
    data_op(0, 4'h0,    1'b1, 32'h10, 32'h0,        1'b1, 32'h11111111);

    // Reset u0 (array retained), then round-robin with both ports held.
    @(posedge clk); #1 rst_v[0] = 1'b1;
    @(posedge clk); #1 rst_v[0] = 1'b0;
    c = cyc;
    i_rd[0] = 1'b1; i_addr[0] = 32'h10;
    d_rd[0] = 1'b1; d_addr[0] = 32'h14;
    sbq[0].push_back(mk(1'b1, 32'h11111111, c + 2));
    sbq[1].push_back(mk(1'b0, 32'h0,        c + 5));
    sbq[0].push_back(mk(1'b1, 32'h11111111, c + 8));
    sbq[1].push_back(mk(1'b0, 32'h0,        c + 11));
    sbq[0].push_back(mk(1'b1, 32'h11111111, c + 14));
    while (cyc < c + 15) begin @(posedge clk); #1; end
    i_rd[0] = 1'b0;
    d_rd[0] = 1'b0;

    // Fixed priority: data wins every tie, instruction waits.
    @(posedge clk); #1;
    c = cyc;
    i_rd[1] = 1'b1; i_addr[1] = 32'h4;
    d_rd[1] = 1'b1; d_addr[1] = 32'h0;
    for (int j = 0; j < 7; j++) sbq[3].push_back(mk(1'b0, 32'h0, c + 2 + 3*j));
    sbq[2].push_back(mk(1'b0, 32'h0, c + 23));
    while (cyc < c + 21) begin @(posedge clk); #1; end
    d_rd[1] = 1'b0;
    while (cyc < c + 24) begin @(posedge clk); #1; end
    i_rd[1] = 1'b0;

    // WAIT=3: reset during the second wait cycle aborts the write.
    data_op(2, 4'hF, 1'b0, 32'h20, 32'h0BADF00D, 1'b0, 32'h0);
    @(posedge clk); #1;
    d_wr[2] = 4'hF; d_addr[2] = 32'h20; d_din[2] = 32'hCAFEF00D;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_v[2] = 1'b1;
    d_wr[2]  = 4'h0;
    @(posedge clk); #1;
    rst_v[2] = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bsy[2] !== 1'b0 || d_rdy[2] !== 1'b0) begin
      n_bad++;
      $display("FAIL abort_idle inst2: got busy %b ready %b, required 0 0", bsy[2], d_rdy[2]);
    end
    repeat (4) @(negedge clk);
    data_op(2, 4'h0, 1'b1, 32'h20, 32'h0, 1'b1, 32'h0BADF00D);

    // DEPTH_LOG2=4: address aliasing and ignored byte offset.
    data_op(3, 4'hF, 1'b0, 32'h40, 32'h12345678, 1'b0, 32'h0);
    data_op(3, 4'h0, 1'b1, 32'h00, 32'h0,        1'b1, 32'h12345678);
    data_op(3, 4'h0, 1'b1, 32'h43, 32'h0,        1'b1, 32'h12345678);

    repeat (5) @(negedge clk);
    for (int g = 0; g < 8; g++) begin
      n_cmp++;
      if (sbq[g].size() != 0) begin
        n_bad++;
        $display("FAIL missing_ready queue%0d: got %0d responses outstanding, required 0",
                 g, sbq[g].size());
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion by 200000 time units, required earlier finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
